// File: rtl/rr_priority_encoder_pkg.sv
// Shared constants and helpers for the round-robin priority encoder.
// Mode encodings are used by both the encoder and anything that drives it.
package rr_priority_encoder_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width for n request lines; never below one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_encoder_if.sv
// Request/grant bundle between a requester and the encoder.
// The encoder uses the slave modport, and the requester/consumer uses the master modport.
interface rr_priority_encoder_if
    import rr_priority_encoder_pkg::*;
#(
    parameter int N    = 8,
    parameter int IDXW = idx_width(N)
);

    logic [N-1:0]    req;
    logic            mode;
    logic            out_valid;
    logic            out_ready;
    logic [IDXW-1:0] out_idx;
    logic [N-1:0]    out_onehot;

    modport master (
        output req,
        output mode,
        output out_ready,
        input  out_valid,
        input  out_idx,
        input  out_onehot
    );

    modport slave (
        input  req,
        input  mode,
        input  out_ready,
        output out_valid,
        output out_idx,
        output out_onehot
    );

endinterface

// File: rtl/rr_priority_encoder_prio_find_msb.sv
// Combinational highest-set-bit finder.
// The found output is low and idx is zero when the vector is empty.
module prio_find_msb
    import rr_priority_encoder_pkg::*;
#(
    parameter int N    = 8,
    parameter int IDXW = idx_width(N)
) (
    input  logic [N-1:0]    vec,
    output logic            found,
    output logic [IDXW-1:0] idx
);

    // Ascending scan so that the last hit, which is the highest index, wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                found = 1'b1;
                idx   = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/rr_priority_encoder.sv
// Registered priority encoder with fixed (highest index) and descending round-robin modes.
// A grant is held until it is accepted, and a new grant can be captured in the accept cycle.
module rr_priority_encoder
    import rr_priority_encoder_pkg::*;
#(
    parameter int N    = 8,
    parameter int IDXW = idx_width(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    rr_priority_encoder_if.slave  bus
);

    logic            valid_q, valid_d;
    logic [IDXW-1:0] idx_q,   idx_d;
    logic            rr_q,    rr_d;
    logic [IDXW-1:0] ptr_q,   ptr_d;

    logic            capture;
    logic            accept;
    logic [N-1:0]    low_mask;
    logic [N-1:0]    req_masked;
    logic            m_found, u_found;
    logic [IDXW-1:0] m_idx,   u_idx;
    logic [IDXW-1:0] sel_idx;

    assign capture = !valid_q || bus.out_ready;
    assign accept  = valid_q && bus.out_ready;

    // The pointer moves before the search so that a same-cycle capture sees the updated value.
    always_comb begin
        ptr_d = ptr_q;
        if (accept && rr_q) begin
            ptr_d = (idx_q == '0) ? IDXW'(N - 1) : idx_q - IDXW'(1);
        end
    end

    always_comb begin
        low_mask = '0;
        for (int i = 0; i < N; i++) begin
            low_mask[i] = (i <= int'(ptr_d));
        end
    end

    assign req_masked = bus.req & low_mask;

    prio_find_msb #(.N(N), .IDXW(IDXW)) u_find_masked (
        .vec   (req_masked),
        .found (m_found),
        .idx   (m_idx)
    );

    prio_find_msb #(.N(N), .IDXW(IDXW)) u_find_all (
        .vec   (bus.req),
        .found (u_found),
        .idx   (u_idx)
    );

    // With nothing at or below P, the highest bit overall is the wrap-around winner.
    always_comb begin
        sel_idx = u_idx;
        if (bus.mode == MODE_RR && m_found) begin
            sel_idx = m_idx;
        end
    end

    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        if (capture) begin
            valid_d = u_found;
            idx_d   = u_found ? sel_idx : '0;
            rr_d    = bus.mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            rr_q    <= MODE_FIXED;
            ptr_q   <= IDXW'(N - 1);
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_idx    = idx_q;
    assign bus.out_onehot = valid_q ? (N'(1) << idx_q) : '0;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Bench for rr_priority_encoder: directed scenarios followed by random traffic.
// Expected grants are pushed to a scoreboard on capture and popped after the edge.
module tb_rr_priority_encoder;

    localparam int N = 8;

    logic clk;
    logic rst;

    rr_priority_encoder_if #(.N(N)) bus ();

    rr_priority_encoder #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [2:0] idx;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic m_valid;
    int   m_idx;
    int   m_ptr;
    logic m_rr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input logic md, input int p);
        if (md) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (p - k + N) % N;
                if (r[i]) return i;
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (r[i]) return i;
            end
        end
        return 0;
    endfunction

    task automatic cycle();
        logic cap, acc;
        exp_t e;
        logic [N-1:0] oh;
        if (rst) begin
            m_valid = 1'b0;
            m_idx   = 0;
            m_ptr   = N - 1;
            m_rr    = 1'b0;
            sb.push_back(exp_t'{v: 1'b0, idx: 3'd0});
        end else begin
            cap = !m_valid || bus.out_ready;
            acc = m_valid && bus.out_ready;
            if (acc && m_rr) m_ptr = (m_idx == 0) ? N - 1 : m_idx - 1;
            if (cap) begin
                m_valid = (bus.req != '0);
                m_idx   = m_valid ? pick(bus.req, bus.mode, m_ptr) : 0;
                m_rr    = bus.mode;
                sb.push_back(exp_t'{v: m_valid, idx: 3'(m_idx)});
            end
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
        end else begin
            e = exp_t'{v: m_valid, idx: 3'(m_idx)};
        end
        oh = '0;
        if (e.v) oh[e.idx] = 1'b1;
        chk("sb_valid",  32'(bus.out_valid),  32'(e.v));
        chk("sb_idx",    32'(bus.out_idx),    32'(e.idx));
        chk("sb_onehot", 32'(bus.out_onehot), 32'(oh));
    endtask

    task automatic drive(input logic [N-1:0] r, input logic md, input logic rdy);
        bus.req       = r;
        bus.mode      = md;
        bus.out_ready = rdy;
        cycle();
    endtask

    initial begin
        int rr_seq[4];
        rr_seq = '{7, 5, 7, 5};

        rst           = 1'b1;
        bus.req       = '0;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b0;
        cycle();
        cycle();
        chk("rst_valid",  32'(bus.out_valid),  32'd0);
        chk("rst_idx",    32'(bus.out_idx),    32'd0);
        chk("rst_onehot", 32'(bus.out_onehot), 32'h00);
        rst = 1'b0;

        // Idle after reset
        for (int k = 0; k < 3; k++) begin
            drive(8'h00, 1'b0, 1'b1);
            chk("idle_valid",  32'(bus.out_valid),  32'd0);
            chk("idle_onehot", 32'(bus.out_onehot), 32'h00);
        end

        // Fixed priority
        drive(8'h29, 1'b0, 1'b1);
        chk("fix_valid",  32'(bus.out_valid),  32'd1);
        chk("fix_idx",    32'(bus.out_idx),    32'd5);
        chk("fix_onehot", 32'(bus.out_onehot), 32'h20);
        drive(8'h01, 1'b0, 1'b1);
        chk("fix_idx0", 32'(bus.out_idx), 32'd0);

        // Round-robin alternation
        for (int k = 0; k < 4; k++) begin
            drive(8'hA0, 1'b1, 1'b1);
            chk("rr_seq", 32'(bus.out_idx), 32'(rr_seq[k]));
        end

        // Stall holds grant and ignores req
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive(8'h81, 1'b1, 1'b0);
        chk("stall_first", 32'(bus.out_idx), 32'd7);
        for (int k = 0; k < 4; k++) begin
            drive(8'h02, 1'b1, 1'b0);
            chk("stall_hold_idx",   32'(bus.out_idx),   32'd7);
            chk("stall_hold_valid", 32'(bus.out_valid), 32'd1);
        end
        drive(8'h01, 1'b1, 1'b1);
        chk("stall_next", 32'(bus.out_idx), 32'd0);

        // Wrap-around search
        drive(8'h08, 1'b1, 1'b1);
        chk("wrap_a", 32'(bus.out_idx), 32'd3);
        drive(8'h08, 1'b1, 1'b1);
        chk("wrap_b", 32'(bus.out_idx), 32'd3);

        // Reset during stall
        drive(8'h40, 1'b1, 1'b1);
        chk("pre_rst_idx", 32'(bus.out_idx), 32'd6);
        drive(8'h40, 1'b1, 1'b0);
        drive(8'h40, 1'b1, 1'b0);
        chk("pre_rst_hold", 32'(bus.out_idx), 32'd6);
        rst = 1'b1;
        cycle();
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_idx",   32'(bus.out_idx),   32'd0);
        rst = 1'b0;
        drive(8'hFF, 1'b1, 1'b1);
        chk("post_rst", 32'(bus.out_idx), 32'd7);

        // Accepting a fixed-mode grant must not move P (P stays 6)
        drive(8'h04, 1'b0, 1'b1);
        chk("fix_single", 32'(bus.out_idx), 32'd2);
        drive(8'hFF, 1'b1, 1'b1);
        chk("fix_keeps_ptr", 32'(bus.out_idx), 32'd6);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic [N-1:0] r;
            case ($urandom_range(0, 3))
                0:       r = '0;
                1:       r = N'(1) << $urandom_range(0, N - 1);
                default: r = N'($urandom);
            endcase
            rst = ($urandom_range(0, 63) == 0);
            drive(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7));
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_priority_encoder.md
RR_PRIORITY_ENCODER -- requirements
Module: rr_priority_encoder

Interface
REQ-001 Parameter N, default 8, meaning number of request lines; legal range 2..32.
REQ-002 Parameter IDXW, default $clog2(N), meaning index width; derived, not overridden.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  N  request vector; bit i high = line i requesting.
REQ-006 mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin.
REQ-007 out_valid  output  1  registered; a grant is held on out_idx/out_onehot.
REQ-008 out_ready  input  1  consumer accepts the grant when out_valid && out_ready.
REQ-009 out_idx  output  IDXW  binary index of granted line.
REQ-010 out_onehot  output  N  one-hot form of out_idx; all-zero when out_valid=0.

Function
REQ-011 Capture condition SHALL be (!out_valid || out_ready); req and mode are sampled only on capture cycles.
REQ-012 Latency SHALL be 1 cycle: req sampled at edge k appears on the outputs after edge k.
REQ-013 On capture with req==0, out_valid SHALL go 0, out_idx SHALL be 0 and out_onehot SHALL be 0; outputs are never undriven or X.
REQ-014 On capture with req!=0, out_valid SHALL go 1 with the selected index.
REQ-015 Stall (out_valid && !out_ready): outputs SHALL hold, and req changes SHALL be ignored; the held grant is never dropped.
REQ-016 Fixed mode: selection SHALL be the highest set bit of req.
REQ-017 Round-robin mode: the search order SHALL be P, P-1, ..., 0, N-1, ..., P+1 (descending with wrap), and the first set bit is granted.
REQ-018 Pointer P SHALL update only on accept of a grant that was captured in RR mode: P <= (g==0) ? N-1 : g-1, where g = accepted out_idx.
REQ-019 Accepts of grants captured in fixed mode SHALL leave P unchanged.
REQ-020 A mode change SHALL take effect at the next capture; a held grant is unaffected.
REQ-021 A single set bit SHALL be granted regardless of P or mode.
REQ-022 Accept and capture in the same cycle SHALL be permitted: P updates and the new grant is computed using the updated P. Back-to-back throughput is 1 grant per cycle.
REQ-023 out_onehot SHALL always equal (1 << out_idx) whenever out_valid=1.

Reset
REQ-024 rst SHALL set out_valid=0, out_idx=0, out_onehot=0 and P=N-1 on the next rising edge.
REQ-025 rst SHALL take priority over capture and accept, including mid-stall; a held grant is discarded.

Structure
REQ-026 Shared package SHALL hold localparams MODE_FIXED=1'b0 and MODE_RR=1'b1, plus the index-width helper function.
REQ-027 One sub-module, prio_find_msb, SHALL be a parametrised combinational highest-set-bit finder returning {found, idx}.
REQ-028 The top SHALL instantiate prio_find_msb twice: once on req masked to bits <=P, once on unmasked req; the masked result wins if found.
REQ-029 Estimated size is 150-250 lines of RTL in total.

Verification (N=8)
REQ-030 Reset, then req=0 for 3 cycles -> out_valid=0, out_idx=0, out_onehot=0x00 throughout.
REQ-031 mode=0, out_ready=1, req=0x29 -> out_idx=5, out_onehot=0x20 one cycle later; req=0x01 -> out_idx=0.
REQ-032 mode=1, out_ready=1, req=0xA0 held constant -> grant sequence 7, 5, 7, 5 on consecutive cycles.
REQ-033 mode=1, req=0x81, out_ready=0 for 4 cycles -> out_idx=7 held stable; then req=0x01 with out_ready=1 -> 7 accepted, next grant 0.
REQ-034 mode=1, grant 3 accepted (P=2), then req=0x08 only -> grant 3 (search wraps).
REQ-035 Assert rst during a stall holding out_idx=6 -> out_valid=0 next cycle; then req=0xFF with mode=1 -> grant 7.
